bdf_code_sequencer: RTL and testbench

//  Reader side of the BDF program store. Steps PC 0..CODE_LENGTH-1 through the code memory and

---
 rtl/bdf_code_sequencer.sv | 119 +++++++++++
 tb/tb_bdf_code_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bdf_code_sequencer.sv
// Reader side of the BDF program store. Walks the code ROM one word at a time and turns each
// word into per-buffer push/pop strobes, issuing a word only when every buffer it names is ready.
module bdf_code_sequencer #(
    parameter int NUM_BUFFERS = 12,
    parameter int CODE_LENGTH = 64,
    parameter int CODE_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   code_rd_en,
    output logic [ADDR_WIDTH-1:0]  code_addr,
    input  logic [CODE_WIDTH-1:0]  code_data,
    input  logic [NUM_BUFFERS-1:0] buf_full,
    input  logic [NUM_BUFFERS-1:0] buf_empty,
    output logic [NUM_BUFFERS-1:0] buf_push,
    output logic [NUM_BUFFERS-1:0] buf_pop,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(CODE_LENGTH - 1);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [CODE_WIDTH-1:0]  code_q;
    logic [NUM_BUFFERS-1:0] dec_push;
    logic [NUM_BUFFERS-1:0] dec_pop;
    logic                   ready;
    logic                   issue;

    // Each buffer owns a 2-bit field: low bit requests a push, high bit requests a pop.
    always_comb begin
        dec_push = '0;
        dec_pop  = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            dec_push[i] = code_q[2*i];
            dec_pop[i]  = code_q[2*i+1];
        end
    end

    // All-or-nothing: a single blocked field holds back the whole word. Strobes are
    // suppressed while reset is asserted so an aborted run never touches the buffers.
    assign ready    = ~|((dec_push & buf_full) | (dec_pop & buf_empty));
    assign issue    = (state == S_ISSUE) && ready && !reset;
    assign buf_push = issue ? dec_push : '0;
    assign buf_pop  = issue ? dec_pop  : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            code_q     <= '0;
            stall_cnt  <= '0;
            code_rd_en <= 1'b0;
            code_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            code_rd_en <= 1'b0;
            code_addr  <= '0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        pc         <= '0;
                        stall_cnt  <= '0;
                        code_rd_en <= 1'b1;
                        code_addr  <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    code_q <= code_data;
                    state  <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ready) begin
                        if (pc == LAST_PC) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            pc         <= pc + 1'b1;
                            state      <= S_FETCH;
                            code_rd_en <= 1'b1;
                            code_addr  <= pc + 1'b1;
                        end
                    end else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    pc    <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bdf_code_sequencer.sv
// Randomised bench for bdf_code_sequencer: a ROM model feeds the sequencer and a word-schedule
// reference model predicts every output each cycle.
module tb_bdf_code_sequencer;

    localparam int NB = 12;
    localparam int CL = 64;
    localparam int CW = 24;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          code_rd_en;
    logic [AW-1:0] code_addr;
    logic [CW-1:0] code_data = '0;
    logic [NB-1:0] buf_full = '0;
    logic [NB-1:0] buf_empty = '0;
    logic [NB-1:0] buf_push;
    logic [NB-1:0] buf_pop;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    logic [CW-1:0] prog [CL];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: which word is next, earliest cycle it may issue, stalls so far.
    int t = 0;
    bit m_active = 1'b0;
    int m_word = 0;
    int m_earliest = 0;
    int m_stall = 0;
    int m_start_t = 0;
    int m_done_t = -1;

    // {busy, done, rd_en, addr[5:0], push[11:0], pop[11:0], stall_cnt[15:0]}
    logic [48:0] obs_v;
    logic [48:0] exp_v;

    bdf_code_sequencer #(
        .NUM_BUFFERS(NB),
        .CODE_LENGTH(CL),
        .CODE_WIDTH (CW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .code_rd_en(code_rd_en),
        .code_addr (code_addr),
        .code_data (code_data),
        .buf_full  (buf_full),
        .buf_empty (buf_empty),
        .buf_push  (buf_push),
        .buf_pop   (buf_pop),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Code ROM: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (code_rd_en) code_data <= prog[code_addr];
    end

    // A word may issue 3 cycles after start or after the previous issue, at the first
    // cycle where none of its pushes hits a full buffer and none of its pops an empty one.
    task automatic model_cycle();
        logic [NB-1:0] pw;
        logic [NB-1:0] pp;
        logic [NB-1:0] ep;
        logic [NB-1:0] eq;
        logic [1:0]    fld;
        logic [AW-1:0] a;
        bit            rd;
        bit            dn;
        bit            bz;
        int            stall_seen;
        pw = '0;
        pp = '0;
        ep = '0;
        eq = '0;
        a  = '0;
        rd = 1'b0;
        dn = m_active && (t == m_done_t);
        bz = m_active && (t > m_start_t);
        stall_seen = m_stall;
        if (m_active && m_word < CL && t == m_earliest - 2) begin
            rd = 1'b1;
            a  = AW'(m_word);
        end
        if (m_active && m_word < CL && t >= m_earliest && !reset) begin
            for (int i = 0; i < NB; i++) begin
                fld   = prog[m_word][2*i +: 2];
                pw[i] = (fld == 2'b01) || (fld == 2'b11);
                pp[i] = (fld == 2'b10) || (fld == 2'b11);
            end
            if ((pw & buf_full) == '0 && (pp & buf_empty) == '0) begin
                ep = pw;
                eq = pp;
                m_word++;
                m_earliest = t + 3;
                if (m_word == CL) m_done_t = t + 1;
            end else if (m_stall < 65535) begin
                m_stall++;
            end
        end
        exp_v = {bz, dn, rd, a, ep, eq, 16'(stall_seen)};
        if (reset) begin
            m_active = 1'b0;
            m_stall  = 0;
        end else if (dn) begin
            m_active = 1'b0;
        end else if (!m_active && start) begin
            m_active   = 1'b1;
            m_word     = 0;
            m_earliest = t + 3;
            m_stall    = 0;
            m_start_t  = t;
            m_done_t   = -1;
        end
        t++;
    endtask

    task automatic tick(input bit s, input logic [NB-1:0] f, input logic [NB-1:0] e, input bit r);
        @(posedge clk);
        #1;
        start     = s;
        buf_full  = f;
        buf_empty = e;
        reset     = r;
        @(negedge clk);
        obs_v = {busy, done, code_rd_en, code_addr, buf_push, buf_pop, stall_cnt};
        model_cycle();
    endtask

    task automatic load_prog(input bit randomize_words);
        for (int i = 0; i < CL; i++) prog[i] = randomize_words ? CW'($urandom) : '0;
    endtask

    task automatic test_reset();
        tick(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0, 1'b1);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL reset_hold t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
        end
        tick(1'b1, '0, '0, 1'b1);
        tick(1'b0, '0, '0, 1'b0);
        vectors++;
        if (obs_v !== exp_v || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_over_start t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
        end
    endtask

    task automatic test_nop_program();
        int t0;
        int done_seen;
        load_prog(1'b0);
        done_seen = -1;
        t0 = t;
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL nop_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (done === 1'b1 && done_seen < 0) done_seen = t - 1 - t0;
        end
        vectors++;
        if (done_seen != 193) begin
            miscompares++;
            $display("[TB] FAIL nop_done_latency actual=%0d required=193", done_seen);
        end
    endtask

    task automatic test_single_push();
        int t0;
        int push_t;
        int push_cycles;
        logic [NB-1:0] push_val;
        load_prog(1'b0);
        prog[0] = 24'h000001;
        push_t = -1;
        push_cycles = 0;
        push_val = '0;
        t0 = t;
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL push_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (buf_push !== '0) begin
                push_cycles++;
                if (push_t < 0) begin
                    push_t = t - 1 - t0;
                    push_val = buf_push;
                end
            end
        end
        vectors++;
        if (push_t != 3 || push_val !== 12'h001 || push_cycles != 1) begin
            miscompares++;
            $display("[TB] FAIL push_first_strobe actual=t%0d/%h/%0dcyc required=t3/001/1cyc",
                     push_t, push_val, push_cycles);
        end
    endtask

    task automatic test_pop_stall();
        logic [NB-1:0] e;
        load_prog(1'b0);
        prog[0] = 24'h000002;
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            e = (i >= 3 && i <= 7) ? 12'h001 : 12'h000;
            tick(1'b0, '0, e, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL pop_stall_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (i == 8) begin
                vectors++;
                if (buf_pop !== 12'h001 || stall_cnt !== 16'd5) begin
                    miscompares++;
                    $display("[TB] FAIL pop_after_stall actual=%h/%0d required=001/5", buf_pop, stall_cnt);
                end
            end
        end
    endtask

    task automatic test_full_block();
        int k;
        logic [NB-1:0] f;
        load_prog(1'b0);
        prog[0] = 24'hFFFFFF;
        k = int'($urandom_range(10, 1));
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 200 + k; i++) begin
            f = (i >= 3 && i < 3 + k) ? 12'h800 : 12'h000;
            tick(1'b0, f, '0, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL full_block_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (i == 3 + k) begin
                vectors++;
                if (buf_push !== 12'hFFF || buf_pop !== 12'hFFF) begin
                    miscompares++;
                    $display("[TB] FAIL full_release actual=%h/%h required=fff/fff", buf_push, buf_pop);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        load_prog(1'b1);
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 34; i++) begin
            tick(1'b0, '0, '0, i == 33);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL abort_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
        end
        vectors++;
        if (busy !== 1'b0 || buf_push !== '0 || buf_pop !== '0 || stall_cnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_state actual=%b/%h/%h/%0d required=0/000/000/0",
                     busy, buf_push, buf_pop, stall_cnt);
        end
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL replay_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (i == 1) begin
                vectors++;
                if (code_rd_en !== 1'b1 || code_addr !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL replay_first_fetch actual=%b/%0d required=1/0", code_rd_en, code_addr);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int fetches;
        int next_addr;
        bit s;
        load_prog(1'b1);
        fetches = 0;
        next_addr = 0;
        tick(1'b1, '0, '0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            s = (i == 2) || (i == 7) || (i == 50) || (i == 100) || (i == 193);
            tick(s, '0, '0, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL start_ignored_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (code_rd_en === 1'b1) begin
                if (code_addr !== AW'(next_addr)) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL pc_sequence actual=%0d required=%0d", code_addr, next_addr);
                end
                next_addr++;
                fetches++;
            end
            if (i == 194) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL start_in_done actual=busy%b required=busy0", busy);
                end
            end
        end
        vectors++;
        if (fetches != CL) begin
            miscompares++;
            $display("[TB] FAIL fetch_count actual=%0d required=%0d", fetches, CL);
        end
    endtask

    task automatic test_random_flags();
        logic [NB-1:0] f;
        logic [NB-1:0] e;
        bit finished;
        int n;
        load_prog(1'b1);
        finished = 1'b0;
        n = 0;
        tick(1'b1, '0, '0, 1'b0);
        while (!finished && n < 8000) begin
            for (int b = 0; b < NB; b++) begin
                f[b] = ($urandom_range(7) == 0);
                e[b] = ($urandom_range(7) == 0);
            end
            tick($urandom_range(49) == 0, f, e, 1'b0);
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random_cycle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
            end
            if (done === 1'b1) finished = 1'b1;
            n++;
        end
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL random_timeout actual=no_done required=done_within_8000");
        end
        tick(1'b0, '0, '0, 1'b0);
        vectors++;
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL random_idle t=%0d actual=%h required=%h", t - 1, obs_v, exp_v);
        end
    endtask

    initial begin
        load_prog(1'b0);
        test_reset();
        test_nop_program();
        test_single_push();
        test_pop_stall();
        test_full_block();
        test_reset_midrun();
        test_start_ignored();
        test_random_flags();
        test_random_flags();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
